// File: rtl/frame_tx_pkg.sv
// frame_tx_pkg: shared state encodings, framing lengths and default
// framing constants for the frame transmit scheduler and its helpers.
package frame_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_HEADER  = 3'd1,
    ST_STREAM  = 3'd2,
    ST_TRAILER = 3'd3,
    ST_DROP    = 3'd4
  } tx_state_t;

  localparam int HEADER_LEN  = 3;
  localparam int TRAILER_LEN = 2;
  localparam int FIFO_DEPTH  = 4;

  localparam logic [15:0] DEFAULT_MAGIC    = 16'hffd8;
  localparam logic [15:0] DEFAULT_TRAILER  = 16'hffd9;
  localparam logic [14:0] DEFAULT_MIN_FREE = 15'd6000;

endpackage

// File: rtl/frame_tx_scheduler_byte_fifo.sv
// byte_fifo: small synchronous FIFO with first-word fall-through read data.
// A push while full is accepted only when a pop happens in the same cycle;
// otherwise the byte is refused and the caller decides what that means.
module byte_fifo #(
  parameter  int DEPTH = 4,
  parameter  int WIDTH = 8,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             nreset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr];

  // Storage array; contents are don't-care until written, so no reset.
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Read/write pointers and occupancy count.
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/frame_tx_scheduler.sv
// frame_tx_scheduler: decides per frame whether to forward it to the UART
// buffer and wraps forwarded frames as magic+id header, payload, trailer.
// Payload always flows through a small FIFO so header bytes can be emitted
// while the first payload bytes are already arriving.
module frame_tx_scheduler
  import frame_tx_pkg::*;
#(
  parameter logic [7:0]  FRAME_SKIP   = 8'd0,
  parameter logic [14:0] MIN_FREE     = DEFAULT_MIN_FREE,
  parameter logic [15:0] HEADER_MAGIC = DEFAULT_MAGIC,
  parameter logic [15:0] TRAILER      = DEFAULT_TRAILER
) (
  input  logic        clock,
  input  logic        nreset,
  input  logic        enable,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  input  logic        in_vsync,
  input  logic [14:0] buf_free,
  output logic        out_valid,
  output logic [7:0]  out_data,
  output logic [7:0]  frame_id,
  output logic [7:0]  dropped_count,
  output logic        overflow,
  output logic [2:0]  state
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);

  tx_state_t   state_q;
  tx_state_t   state_d;
  logic [1:0]  idx_q;
  logic [1:0]  idx_d;
  logic        vsync_q;
  logic        rise;
  logic        fall;
  logic [7:0]  skip_cnt;
  logic        end_pending;

  logic        fifo_push;
  logic        fifo_pop;
  logic        fifo_full;
  logic        fifo_empty;
  logic [7:0]  fifo_dout;
  logic [CW-1:0] fifo_count;
  logic        fifo_empty_next;
  logic        byte_lost;

  logic        skip_load;
  logic        skip_dec;
  logic        drop_inc;
  logic        id_inc;
  logic        end_set;
  logic        end_clr;
  logic        emit_valid;
  logic [7:0]  emit_data;

  assign rise  = in_vsync & ~vsync_q;
  assign fall  = ~in_vsync & vsync_q;
  assign state = state_q;

  // Payload is only buffered while a forwarded frame is being built.
  assign fifo_push = in_valid & ((state_q == ST_HEADER) | (state_q == ST_STREAM));
  assign fifo_pop  = (state_q == ST_STREAM) & ~fifo_empty;
  assign byte_lost = fifo_push & fifo_full & ~fifo_pop;

  // Looking at the FIFO after this edge lets the trailer follow the last
  // payload byte back-to-back instead of leaving an idle cycle.
  assign fifo_empty_next = (fifo_empty & ~fifo_push) |
                           ((fifo_count == CW'(1)) & fifo_pop & ~fifo_push);

  byte_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clock  (clock),
    .nreset (nreset),
    .push   (fifo_push),
    .pop    (fifo_pop),
    .din    (in_data),
    .dout   (fifo_dout),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .count  (fifo_count)
  );

  // Next-state, framing byte selection and bookkeeping strobes.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    skip_load  = 1'b0;
    skip_dec   = 1'b0;
    drop_inc   = 1'b0;
    id_inc     = 1'b0;
    end_set    = 1'b0;
    end_clr    = 1'b0;
    emit_valid = 1'b0;
    emit_data  = 8'h00;

    case (state_q)
      ST_IDLE: begin
        if (rise) begin
          if (!enable) begin
            state_d = ST_DROP;
          end else if (skip_cnt != 8'd0) begin
            skip_dec = 1'b1;
            state_d  = ST_DROP;
          end else if (buf_free < MIN_FREE) begin
            drop_inc = 1'b1;
            state_d  = ST_DROP;
          end else begin
            skip_load = 1'b1;
            idx_d     = 2'd0;
            state_d   = ST_HEADER;
          end
        end
      end

      ST_HEADER: begin
        emit_valid = 1'b1;
        case (idx_q)
          2'd0:    emit_data = HEADER_MAGIC[15:8];
          2'd1:    emit_data = HEADER_MAGIC[7:0];
          default: emit_data = frame_id;
        endcase
        // A very short frame can end while the header is still going out.
        if (fall) end_set = 1'b1;
        if (idx_q == 2'(HEADER_LEN - 1)) begin
          idx_d   = 2'd0;
          state_d = ST_STREAM;
        end else begin
          idx_d = idx_q + 2'd1;
        end
      end

      ST_STREAM: begin
        emit_valid = fifo_pop;
        emit_data  = fifo_dout;
        if (fall) end_set = 1'b1;
        if ((end_pending | fall) & fifo_empty_next) begin
          idx_d   = 2'd0;
          state_d = ST_TRAILER;
        end
      end

      ST_TRAILER: begin
        emit_valid = 1'b1;
        emit_data  = (idx_q == 2'd0) ? TRAILER[15:8] : TRAILER[7:0];
        if (idx_q == 2'(TRAILER_LEN - 1)) begin
          id_inc  = 1'b1;
          end_clr = 1'b1;
          idx_d   = 2'd0;
          state_d = ST_IDLE;
        end else begin
          idx_d = idx_q + 2'd1;
        end
      end

      ST_DROP: begin
        if (fall) state_d = ST_IDLE;
      end

      default: begin
        idx_d   = 2'd0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // Frame-boundary history for rise/fall detection.
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) vsync_q <= 1'b0;
    else         vsync_q <= in_vsync;
  end

  // FSM state and header/trailer byte index.
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      state_q <= ST_IDLE;
      idx_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Decimation counter: reloaded on each forwarded frame, counts down on skips.
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset)        skip_cnt <= 8'd0;
    else if (skip_load) skip_cnt <= FRAME_SKIP;
    else if (skip_dec)  skip_cnt <= skip_cnt - 8'd1;
  end

  // Frame id, saturating drop counter, sticky overflow and end-of-frame flag.
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      frame_id      <= 8'd0;
      dropped_count <= 8'd0;
      overflow      <= 1'b0;
      end_pending   <= 1'b0;
    end else begin
      if (id_inc) frame_id <= frame_id + 8'd1;
      if (drop_inc && dropped_count != 8'hff) dropped_count <= dropped_count + 8'd1;
      if (byte_lost) overflow <= 1'b1;
      if (end_clr)      end_pending <= 1'b0;
      else if (end_set) end_pending <= 1'b1;
    end
  end

  // Registered output byte; data holds its last value between strobes.
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      out_valid <= 1'b0;
      out_data  <= 8'h00;
    end else begin
      out_valid <= emit_valid;
      if (emit_valid) out_data <= emit_data;
    end
  end

endmodule

// File: doc/frame_tx_scheduler.md
# frame_tx_scheduler

Sequences compressed frames from the JPEG core into the SPRAM UART output buffer. For each frame it decides whether to forward it, based on enable, frame decimation and free buffer space. A forwarded frame is wrapped as a 3-byte header (magic + frame id), the payload bytes, and a 2-byte FF D9 trailer. It sits between the jfpjc output (`hsync` as byte valid, `vsync` as frame-active) and `spram_uart_buffer`, replacing the bare end-of-frame stuffer.

## Interface
- `FRAME_SKIP`, 0: forward 1 of every FRAME_SKIP+1 eligible frames (8-bit counter).
- `MIN_FREE`, 15'd6000: minimum `buf_free` sampled at frame start to accept a frame.
- `HEADER_MAGIC`, 16'hffd8: first two header bytes, MSB first.
- `TRAILER`, 16'hffd9: trailer bytes, MSB first.
- `clock`  in  1  system clock (osc_12m domain); all inputs synchronous to it.
- `nreset`  in  1  asynchronous, active-low reset.
- `enable`  in  1  when low, new frames are not accepted; a frame in progress completes.
- `in_valid`  in  1  payload byte strobe; no backpressure.
- `in_data`  in  8  payload byte.
- `in_vsync`  in  1  high while a frame is active.
- `buf_free`  in  15  free bytes in the output buffer.
- `out_valid`  out  1  output byte strobe, registered.
- `out_data`  out  8  output byte, registered.
- `frame_id`  out  8  id of the next forwarded frame.
- `dropped_count`  out  8  frames rejected for low `buf_free`; saturates at 255.
- `overflow`  out  1  sticky; set when a payload byte was lost to a full FIFO.
- `state`  out  3  current FSM state, for debug.

## Operation
- Edge detect: `vsync_q` is registered `in_vsync`. rise = `in_vsync & ~vsync_q`; fall = `~in_vsync & vsync_q`.
- All payload bytes pass through a 4-entry byte FIFO. Output is a mux between the FIFO and the header/trailer generator.
- States: IDLE=0, HEADER=1, STREAM=2, TRAILER=3, DROP=4.
- IDLE, on rise:
  - `enable` low → DROP.
  - else `skip_cnt` ≠ 0 → `skip_cnt`--, DROP.
  - else `buf_free` < `MIN_FREE` → DROP, `dropped_count`++ (saturating); `skip_cnt` unchanged.
  - else → HEADER, `skip_cnt` <= `FRAME_SKIP`.
- IDLE with `in_vsync` already high and no rise (mid-frame join): stay IDLE and ignore bytes.
- HEADER: emits `HEADER_MAGIC[15:8]`, `HEADER_MAGIC[7:0]`, `frame_id` on 3 consecutive cycles, then → STREAM. Payload arriving meanwhile is pushed to the FIFO.
- STREAM: pops one FIFO byte per cycle when non-empty. `end_pending` is set on fall. When `end_pending` is set and the FIFO is empty → TRAILER.
- TRAILER: emits `TRAILER[15:8]`, `TRAILER[7:0]`, then `frame_id`++ (wraps 255→0), clears `end_pending`, → IDLE.
- DROP: discards `in_valid` bytes (no FIFO push); on fall → IDLE.
- FIFO push happens only in HEADER and STREAM. A push while full drops the byte and sets `overflow`. Simultaneous push and pop while full is legal; no loss.
- A rise seen in HEADER, STREAM or TRAILER is ignored. That frame's bytes are handled per the current state, and it receives no header.

## Timing
- Reset values: `out_valid`=0, `out_data`=0, `frame_id`=0, `dropped_count`=0, `overflow`=0, `state`=IDLE, `skip_cnt`=0, FIFO empty, `end_pending`=0, `vsync_q`=0.
- Rise sampled at edge N → state HEADER after N → first header byte valid after edge N+1; header bytes appear after edges N+1, N+2, N+3.
- STREAM payload latency: byte sampled at edge k (FIFO empty, no header pending) → `out_valid` after edge k+1.
- Trailer: first byte one cycle after the last payload byte when the fall has already been seen; otherwise the cycle after fall detection.
- Throughput: at most one output byte per cycle.
- Mid-operation reset: everything returns to reset values at once. No partial trailer is emitted.

## Structure
- Shared package `frame_tx_pkg` holds the state encodings, the 3/2 header/trailer lengths, and the default magic values.
- Sub-module `byte_fifo` (parameterised depth, default 4): synchronous, with `push`, `pop`, `full`, `empty` and same-cycle push/pop.
- `frame_tx_scheduler` contains the FSM, edge detect, counters and the output mux.

## Test plan
- Defaults, `buf_free`=8000, one frame of bytes 01..10 → out: FF D8 00 01..10 FF D9; `frame_id` becomes 1.
- `FRAME_SKIP`=2, 6 frames → frames 1 and 4 forwarded, with ids 00 and 01; `dropped_count`=0.
- `buf_free`=100 at frame start → no output, `dropped_count`=1. Next frame with `buf_free`=8000 → forwarded with id 00.
- `in_valid` every cycle from the rise for 20 bytes → all 20 bytes output in order after the 3-byte header, `overflow`=0. Hold `out_valid`-side pops off by forcing 5 pushes while full → `overflow`=1.
- Fall in the same cycle as the last byte → trailer immediately follows that byte. `enable` dropped mid-frame → trailer still emitted, next frame dropped.
- Assert `nreset` mid-payload → `out_valid`=0 next cycle, `frame_id`=0; next rise produces a full fresh frame.
